// File: rtl/fft_sdf_stage8_if.sv
// Stream bundle for the 8-span SDF stage.
// Carries samples and ROM phase/twiddle in, and the registered results out.
interface fft_sdf_stage8_if #(parameter int DATA_W = 24);
   logic              in_valid;
   logic [DATA_W-1:0] din_r;
   logic [DATA_W-1:0] din_i;
   logic [1:0]        state;
   logic [DATA_W-1:0] w_r;
   logic [DATA_W-1:0] w_i;
   logic              out_valid;
   logic [DATA_W-1:0] dout_r;
   logic [DATA_W-1:0] dout_i;

   modport master (
      output in_valid, din_r, din_i, state, w_r, w_i,
      input  out_valid, dout_r, dout_i
   );

   modport slave (
      input  in_valid, din_r, din_i, state, w_r, w_i,
      output out_valid, dout_r, dout_i
   );
endinterface

// File: rtl/fft_sdf_stage8.sv
// Radix-2 single-delay-feedback butterfly stage (span 8, 16-sample frames).
// Phase and twiddle come from an external ROM; this block only reacts to them.
module fft_sdf_stage8 #(
   parameter int DATA_W = 24,
   parameter int FRAC   = 8,
   parameter int DEPTH  = 8
) (
   input logic             clk,
   input logic             rst_n,
   fft_sdf_stage8_if.slave bus
);

   typedef enum logic [1:0] {
      PH_FILL = 2'd0,
      PH_BFLY = 2'd1,
      PH_TWID = 2'd2,
      PH_IDLE = 2'd3
   } phase_t;

   typedef logic signed [DATA_W-1:0]   word_t;
   typedef logic signed [2*DATA_W-1:0] wide_t;

   phase_t phase;
   word_t  dl_r [DEPTH];
   word_t  dl_i [DEPTH];
   word_t  d_r, d_i, h_r, h_i, w_r, w_i;
   wide_t  prod_r, prod_i;
   word_t  res_r, res_i, tail_r, tail_i;
   logic   shift, load, valid_nxt;

   assign phase = phase_t'(bus.state);
   assign d_r   = bus.in_valid ? word_t'(bus.din_r) : '0;
   assign d_i   = bus.in_valid ? word_t'(bus.din_i) : '0;
   assign h_r   = dl_r[0];
   assign h_i   = dl_i[0];
   assign w_r   = bus.w_r;
   assign w_i   = bus.w_i;

   // Operands are sign-extended first so the products are exact at 2*DATA_W.
   assign prod_r = wide_t'(h_r) * wide_t'(w_r) - wide_t'(h_i) * wide_t'(w_i);
   assign prod_i = wide_t'(h_r) * wide_t'(w_i) + wide_t'(h_i) * wide_t'(w_r);

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      shift     = 1'b0;
      load      = 1'b0;
      valid_nxt = 1'b0;
      res_r     = '0;
      res_i     = '0;
      tail_r    = d_r;
      tail_i    = d_i;
      case (phase)
         PH_FILL: shift = bus.in_valid;
         PH_BFLY: begin
            shift     = 1'b1;
            load      = 1'b1;
            valid_nxt = 1'b1;
            res_r     = h_r + d_r;
            res_i     = h_i + d_i;
            tail_r    = h_r - d_r;
            tail_i    = h_i - d_i;
         end
         PH_TWID: begin
            shift     = 1'b1;
            load      = 1'b1;
            valid_nxt = 1'b1;
            res_r     = word_t'(prod_r >>> FRAC);
            res_i     = word_t'(prod_i >>> FRAC);
         end
         default: ;
      endcase
   end

   // NOTE: the delay line is cleared by reset so a mid-frame reset cannot leak stale partial sums.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.dout_r    <= '0;
         bus.dout_i    <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            dl_r[k] <= '0;
            dl_i[k] <= '0;
         end
      end else begin
         bus.out_valid <= valid_nxt;
         if (load) begin
            bus.dout_r <= res_r;
            bus.dout_i <= res_i;
         end
         if (shift) begin
            for (int k = 0; k < DEPTH - 1; k++) begin
               dl_r[k] <= dl_r[k+1];
               dl_i[k] <= dl_i[k+1];
            end
            dl_r[DEPTH-1] <= tail_r;
            dl_i[DEPTH-1] <= tail_i;
         end
      end
   end

endmodule

// File: tb/tb_fft_sdf_stage8.sv
// Self-checking bench for fft_sdf_stage8: fixed vectors, impulse, random frames, mid-frame reset.
// Expected outputs come from a frame-level model: sums x[n]+x[n+8], then (x[n]-x[n+8])*w >>> 8.
module tb_fft_sdf_stage8;

   localparam int MAXF = 6;

   typedef struct {
      logic [23:0] ar, ai, br, bi, wr, wi;
      logic [47:0] sum, tw;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fft_sdf_stage8_if #(.DATA_W(24)) bus ();

   fft_sdf_stage8 #(.DATA_W(24), .FRAC(8), .DEPTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;
   int valid_seen;
   logic [47:0] hold;
   logic [47:0] expq [$];

   logic [23:0] fr_r [MAXF][16];
   logic [23:0] fr_i [MAXF][16];
   logic [23:0] tw_r [MAXF][8];
   logic [23:0] tw_i [MAXF][8];

   int rom_r [8] = '{256, 237, 181, 98, 0, -98, -181, -237};
   int rom_i [8] = '{0, -98, -181, -237, -256, -237, -181, -98};

   vec_t tbl [5];

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [23:0] rnd24();
      return 24'($urandom);
   endfunction

   function automatic logic [47:0] bfly(input logic [23:0] ar, ai, br, bi);
      logic [23:0] sr, si;
      sr = ar + br;
      si = ai + bi;
      return {sr, si};
   endfunction

   function automatic logic [47:0] twid(input logic [23:0] ar, ai, br, bi, wr, wi);
      logic [23:0] hr, hi;
      longint pr, pi;
      hr = ar - br;
      hi = ai - bi;
      pr = longint'($signed(hr)) * longint'($signed(wr)) - longint'($signed(hi)) * longint'($signed(wi));
      pi = longint'($signed(hr)) * longint'($signed(wi)) + longint'($signed(hi)) * longint'($signed(wr));
      pr = pr >>> 8;
      pi = pi >>> 8;
      return {pr[23:0], pi[23:0]};
   endfunction

   task automatic build_expected(input int nf);
      for (int f = 0; f < nf; f++) begin
         for (int n = 0; n < 8; n++)
            expq.push_back(bfly(fr_r[f][n], fr_i[f][n], fr_r[f][n+8], fr_i[f][n+8]));
         for (int n = 0; n < 8; n++)
            expq.push_back(twid(fr_r[f][n], fr_i[f][n], fr_r[f][n+8], fr_i[f][n+8],
                                tw_r[f][n], tw_i[f][n]));
      end
   endtask

   // One clock: drive inputs, then compare outputs #1 after the edge.
   task automatic step(input logic [1:0] st, input logic v,
                       input logic [23:0] dr, di, wr, wi);
      logic [47:0] e;
      bus.state = st; bus.in_valid = v;
      bus.din_r = dr; bus.din_i = di;
      bus.w_r   = wr; bus.w_i   = wi;
      @(posedge clk);
      #1;
      if (st == 2'd1 || st == 2'd2) begin
         valid_seen++;
         check("out_valid_hi", {47'd0, bus.out_valid}, 48'd1);
         if (expq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL expq_underflow: got output %h want none", {bus.dout_r, bus.dout_i});
         end else begin
            e = expq.pop_front();
            check("dout", {bus.dout_r, bus.dout_i}, e);
            hold = e;
         end
      end else begin
         check("out_valid_lo", {47'd0, bus.out_valid}, 48'd0);
         check("dout_hold", {bus.dout_r, bus.dout_i}, hold);
      end
   endtask

   // Fill, then alternate butterfly/twiddle; twiddle phase overlaps the next frame's fill.
   task automatic drive_frames(input int nf, input bit gaps);
      for (int n = 0; n < 8; n++) begin
         if (gaps && $urandom_range(2) == 0) step(2'd0, 1'b0, rnd24(), rnd24(), rnd24(), rnd24());
         step(2'd0, 1'b1, fr_r[0][n], fr_i[0][n], rnd24(), rnd24());
      end
      for (int f = 0; f < nf; f++) begin
         for (int n = 0; n < 8; n++) begin
            if (gaps && $urandom_range(4) == 0)
               step(2'd3, 1'($urandom_range(1)), rnd24(), rnd24(), rnd24(), rnd24());
            step(2'd1, 1'b1, fr_r[f][n+8], fr_i[f][n+8], rnd24(), rnd24());
         end
         for (int n = 0; n < 8; n++) begin
            if (gaps && $urandom_range(4) == 0)
               step(2'd3, 1'($urandom_range(1)), rnd24(), rnd24(), rnd24(), rnd24());
            if (f < nf - 1) step(2'd2, 1'b1, fr_r[f+1][n], fr_i[f+1][n], tw_r[f][n], tw_i[f][n]);
            else            step(2'd2, 1'b0, rnd24(), rnd24(), tw_r[f][n], tw_i[f][n]);
         end
      end
   endtask

   task automatic load_const_frame(input logic [23:0] ar, ai, br, bi, wr, wi);
      for (int n = 0; n < 8; n++) begin
         fr_r[0][n] = ar;   fr_i[0][n] = ai;
         fr_r[0][n+8] = br; fr_i[0][n+8] = bi;
         tw_r[0][n] = wr;   tw_i[0][n] = wi;
      end
   endtask

   initial begin
      tbl[0] = '{24'd256, 24'd0, 24'd256, 24'd0, 24'd256, 24'd0, {24'd512, 24'd0}, {24'd0, 24'd0}};
      tbl[1] = '{24'd256, 24'd0, 24'd0, 24'd0, 24'd181, 24'd181, {24'd256, 24'd0}, {24'd181, 24'd181}};
      tbl[2] = '{24'd0, 24'd256, 24'd0, 24'd0, 24'd181, 24'd181, {24'd0, 24'd256}, {24'hFFFF4B, 24'd181}};
      tbl[3] = '{24'd1, 24'd0, 24'd0, 24'd0, 24'hFFFF4B, 24'd0, {24'd1, 24'd0}, {24'hFFFFFF, 24'd0}};
      tbl[4] = '{24'h7FFFFF, 24'd0, 24'd1, 24'd0, 24'd256, 24'd0, {24'h800000, 24'd0}, {24'h7FFFFE, 24'd0}};

      rst_n = 1'b0;
      bus.state = 2'd0; bus.in_valid = 1'b0;
      bus.din_r = '0; bus.din_i = '0; bus.w_r = '0; bus.w_i = '0;
      hold = '0;
      valid_seen = 0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_out_valid", {47'd0, bus.out_valid}, 48'd0);
      check("reset_dout", {bus.dout_r, bus.dout_i}, 48'd0);
      rst_n = 1'b1;

      // Fixed vectors: DC, twiddle multiply, negative truncation, wrap-around.
      for (int t = 0; t < 5; t++) begin
         load_const_frame(tbl[t].ar, tbl[t].ai, tbl[t].br, tbl[t].bi, tbl[t].wr, tbl[t].wi);
         for (int n = 0; n < 8; n++) expq.push_back(tbl[t].sum);
         for (int n = 0; n < 8; n++) expq.push_back(tbl[t].tw);
         drive_frames(1, 1'b0);
      end

      // Impulse with ROM twiddles.
      for (int n = 0; n < 16; n++) begin
         fr_r[0][n] = (n == 0) ? 24'd256 : 24'd0;
         fr_i[0][n] = 24'd0;
      end
      for (int n = 0; n < 8; n++) begin
         tw_r[0][n] = 24'(rom_r[n]);
         tw_i[0][n] = 24'(rom_i[n]);
      end
      expq.push_back({24'd256, 24'd0});
      for (int n = 0; n < 7; n++) expq.push_back(48'd0);
      expq.push_back({24'd256, 24'd0});
      for (int n = 0; n < 7; n++) expq.push_back(48'd0);
      valid_seen = 0;
      drive_frames(1, 1'b0);
      check("impulse_valid_count", 48'(valid_seen), 48'd16);

      // Random back-to-back frames with idle gaps.
      for (int r = 0; r < 3; r++) begin
         for (int f = 0; f < MAXF; f++) begin
            for (int n = 0; n < 16; n++) begin
               fr_r[f][n] = rnd24();
               fr_i[f][n] = rnd24();
            end
            for (int n = 0; n < 8; n++) begin
               tw_r[f][n] = rnd24();
               tw_i[f][n] = rnd24();
            end
         end
         build_expected(MAXF);
         drive_frames(MAXF, 1'b1);
      end

      // Reset asserted mid-butterfly: outputs clear at once, delay line is emptied.
      load_const_frame(24'd256, 24'd0, 24'd256, 24'd0, 24'd256, 24'd0);
      for (int n = 0; n < 8; n++) step(2'd0, 1'b1, 24'd256, 24'd0, 24'd0, 24'd0);
      for (int n = 0; n < 3; n++) begin
         expq.push_back({24'd512, 24'd0});
         step(2'd1, 1'b1, 24'd256, 24'd0, 24'd0, 24'd0);
      end
      #2 rst_n = 1'b0;
      #1;
      check("midreset_out_valid", {47'd0, bus.out_valid}, 48'd0);
      check("midreset_dout", {bus.dout_r, bus.dout_i}, 48'd0);
      hold = '0;
      rst_n = 1'b1;
      expq.push_back(48'd0);
      step(2'd1, 1'b1, 24'd0, 24'd0, 24'd0, 24'd0);
      build_expected(1);
      drive_frames(1, 1'b0);

      check("expq_drained", 48'(expq.size()), 48'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
